// File: rtl/reset_sequencer_if.sv
// Control and status bundle of the reset sequencer: software reset request
// and hold going in, sequenced resets and progress flags coming out.
interface reset_sequencer_if #(
   parameter int NUM_OUT = 4
);
   logic               sw_rst_req;
   logic               hold;
   logic [NUM_OUT-1:0] rst_out;
   logic               busy;
   logic               done;

   modport master (
      output sw_rst_req,
      output hold,
      input  rst_out,
      input  busy,
      input  done
   );

   modport slave (
      input  sw_rst_req,
      input  hold,
      output rst_out,
      output busy,
      output done
   );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: turns one asynchronous active-low reset into NUM_OUT
// active-high resets that assert at once, release synchronously and release
// one after another (bit 0 first) after a stretch, spaced by a gap.
// A software request re-runs the release sequence from the stretch phase.
module reset_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUT     = 4,
   parameter int STRETCH     = 16,
   parameter int GAP         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   reset_sequencer_if.slave  bus
);

   localparam int CNT_MAX = (STRETCH > GAP) ? STRETCH : GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
   localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_STRETCH = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // The ASSERT->STRETCH decision of the state register acts as the final
   // synchronizer stage, so only SYNC_STAGES-1 dedicated flops are needed
   // to get SYNC_STAGES flops of settling between rst_n and the sequence.
   logic [SYNC_STAGES-2:0] sync_q;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_OUT-1:0]  rst_out_q, rst_out_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                sw_take;
   logic                release_evt;
   logic                last_bit;

   // Software request counts in every state except ASSERT.
   assign sw_take  = bus.sw_rst_req && (state_q != ST_ASSERT);
   // Ones are contiguous from the top, so one left shift releases the lowest
   // asserted bit; an all-zero result means this is the final release.
   assign last_bit = ((rst_out_q << 1) == '0);

   // Synchronizer chain: cleared asynchronously, fills with ones after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= (sync_q << 1) | (SYNC_STAGES-1)'(1);
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ASSERT;
         cnt_q     <= '0;
         rst_out_q <= '1;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rst_out_q <= rst_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and counter logic; software request beats hold.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      release_evt = 1'b0;
      case (state_q)
         ST_ASSERT: begin
            if (sync_q[SYNC_STAGES-2]) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end
         end
         ST_STRETCH: begin
            if (sw_take) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end else if (!bus.hold) begin
               if (cnt_q == STRETCH_LAST) begin
                  release_evt = 1'b1;
                  cnt_d       = '0;
                  state_d     = last_bit ? ST_DONE : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_RELEASE: begin
            if (sw_take) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end else if (!bus.hold) begin
               if (cnt_q == GAP_LAST) begin
                  release_evt = 1'b1;
                  cnt_d       = '0;
                  state_d     = last_bit ? ST_DONE : ST_RELEASE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_DONE: begin
            if (sw_take) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
         end
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      rst_out_d = rst_out_q;
      busy_d    = busy_q;
      done_d    = done_q;
      if (sw_take) begin
         rst_out_d = '1;
         busy_d    = 1'b1;
         done_d    = 1'b0;
      end else if (release_evt) begin
         rst_out_d = rst_out_q << 1;
         if (last_bit) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   assign bus.rst_out = rst_out_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

   logic clk;
   logic rst_n_a;
   logic rst_n_b;
   int   n_cmp;
   int   n_err;

   reset_sequencer_if #(.NUM_OUT(4)) bus_a ();
   reset_sequencer_if #(.NUM_OUT(1)) bus_b ();

   reset_sequencer #(
      .SYNC_STAGES(2), .NUM_OUT(4), .STRETCH(16), .GAP(8)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n_a),
      .bus   (bus_a)
   );

   reset_sequencer #(
      .SYNC_STAGES(3), .NUM_OUT(1), .STRETCH(1), .GAP(1)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold reset low for a few cycles, release before edge 1.
   task automatic restart_a();
      rst_n_a = 1'b0;
      step(3);
      @(negedge clk);
      rst_n_a = 1'b1;
   endtask

   task automatic test_reset();
      bus_a.sw_rst_req = 1'b0;
      bus_a.hold       = 1'b0;
      rst_n_a          = 1'b1;
      step(2);
      #2;
      rst_n_a = 1'b0;
      #1;
      n_cmp++; if (bus_a.rst_out !== 4'b1111) begin n_err++; $display("FAIL reset_rst_out got %b want 1111", bus_a.rst_out); end
      n_cmp++; if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", bus_a.busy); end
      n_cmp++; if (bus_a.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus_a.done); end
   endtask

   task automatic test_powerup();
      restart_a();
      step(17);
      n_cmp++; if (bus_a.rst_out !== 4'b1111) begin n_err++; $display("FAIL pwr_e17 got %b want 1111", bus_a.rst_out); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL pwr_e18 got %b want 1110", bus_a.rst_out); end
      step(7);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL pwr_e25 got %b want 1110", bus_a.rst_out); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b1100) begin n_err++; $display("FAIL pwr_e26 got %b want 1100", bus_a.rst_out); end
      step(8);
      n_cmp++; if (bus_a.rst_out !== 4'b1000) begin n_err++; $display("FAIL pwr_e34 got %b want 1000", bus_a.rst_out); end
      step(7);
      n_cmp++; if ({bus_a.busy, bus_a.done} !== 2'b10) begin n_err++; $display("FAIL pwr_e41_busy_done got %b want 10", {bus_a.busy, bus_a.done}); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b0000) begin n_err++; $display("FAIL pwr_e42 got %b want 0000", bus_a.rst_out); end
      n_cmp++; if ({bus_a.busy, bus_a.done} !== 2'b01) begin n_err++; $display("FAIL pwr_e42_busy_done got %b want 01", {bus_a.busy, bus_a.done}); end
   endtask

   task automatic test_async_mid();
      restart_a();
      step(26);
      n_cmp++; if (bus_a.rst_out !== 4'b1100) begin n_err++; $display("FAIL async_pre got %b want 1100", bus_a.rst_out); end
      #2;
      rst_n_a = 1'b0;
      #1;
      n_cmp++; if (bus_a.rst_out !== 4'b1111) begin n_err++; $display("FAIL async_assert got %b want 1111", bus_a.rst_out); end
      n_cmp++; if ({bus_a.busy, bus_a.done} !== 2'b10) begin n_err++; $display("FAIL async_busy_done got %b want 10", {bus_a.busy, bus_a.done}); end
      @(negedge clk);
      rst_n_a = 1'b1;
      step(17);
      n_cmp++; if (bus_a.rst_out !== 4'b1111) begin n_err++; $display("FAIL async_e17 got %b want 1111", bus_a.rst_out); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL async_e18 got %b want 1110", bus_a.rst_out); end
      step(24);
      n_cmp++; if ({bus_a.rst_out, bus_a.done} !== 5'b00001) begin n_err++; $display("FAIL async_e42 got %b want 00001", {bus_a.rst_out, bus_a.done}); end
   endtask

   task automatic test_hold();
      restart_a();
      step(5);
      bus_a.hold = 1'b1;
      step(5);
      bus_a.hold = 1'b0;
      step(12);
      n_cmp++; if (bus_a.rst_out !== 4'b1111) begin n_err++; $display("FAIL hold_e22 got %b want 1111", bus_a.rst_out); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL hold_e23 got %b want 1110", bus_a.rst_out); end
      step(7);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL hold_e30 got %b want 1110", bus_a.rst_out); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b1100) begin n_err++; $display("FAIL hold_e31 got %b want 1100", bus_a.rst_out); end
      step(8);
      n_cmp++; if (bus_a.rst_out !== 4'b1000) begin n_err++; $display("FAIL hold_e39 got %b want 1000", bus_a.rst_out); end
      step(7);
      n_cmp++; if ({bus_a.rst_out, bus_a.busy} !== 5'b10001) begin n_err++; $display("FAIL hold_e46 got %b want 10001", {bus_a.rst_out, bus_a.busy}); end
      step(1);
      n_cmp++; if ({bus_a.rst_out, bus_a.busy, bus_a.done} !== 6'b000001) begin n_err++; $display("FAIL hold_e47 got %b want 000001", {bus_a.rst_out, bus_a.busy, bus_a.done}); end
   endtask

   task automatic test_sw_from_done();
      bus_a.sw_rst_req = 1'b1;
      step(1);
      bus_a.sw_rst_req = 1'b0;
      n_cmp++; if ({bus_a.rst_out, bus_a.busy, bus_a.done} !== 6'b111110) begin n_err++; $display("FAIL swd_T got %b want 111110", {bus_a.rst_out, bus_a.busy, bus_a.done}); end
      step(15);
      n_cmp++; if (bus_a.rst_out !== 4'b1111) begin n_err++; $display("FAIL swd_T15 got %b want 1111", bus_a.rst_out); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL swd_T16 got %b want 1110", bus_a.rst_out); end
      step(23);
      n_cmp++; if (bus_a.rst_out !== 4'b1000) begin n_err++; $display("FAIL swd_T39 got %b want 1000", bus_a.rst_out); end
      step(1);
      n_cmp++; if ({bus_a.rst_out, bus_a.done} !== 5'b00001) begin n_err++; $display("FAIL swd_T40 got %b want 00001", {bus_a.rst_out, bus_a.done}); end
   endtask

   task automatic test_sw_hold_release();
      bus_a.sw_rst_req = 1'b1;
      step(1);
      bus_a.sw_rst_req = 1'b0;
      step(20);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL swh_pre got %b want 1110", bus_a.rst_out); end
      bus_a.sw_rst_req = 1'b1;
      bus_a.hold       = 1'b1;
      step(1);
      bus_a.sw_rst_req = 1'b0;
      bus_a.hold       = 1'b0;
      n_cmp++; if ({bus_a.rst_out, bus_a.busy, bus_a.done} !== 6'b111110) begin n_err++; $display("FAIL swh_U got %b want 111110", {bus_a.rst_out, bus_a.busy, bus_a.done}); end
      step(15);
      n_cmp++; if (bus_a.rst_out !== 4'b1111) begin n_err++; $display("FAIL swh_U15 got %b want 1111", bus_a.rst_out); end
      step(1);
      n_cmp++; if (bus_a.rst_out !== 4'b1110) begin n_err++; $display("FAIL swh_U16 got %b want 1110", bus_a.rst_out); end
   endtask

   task automatic test_corner();
      n_cmp++; if ({bus_b.rst_out, bus_b.busy, bus_b.done} !== 3'b110) begin n_err++; $display("FAIL crn_reset got %b want 110", {bus_b.rst_out, bus_b.busy, bus_b.done}); end
      @(negedge clk);
      rst_n_b = 1'b1;
      bus_b.sw_rst_req = 1'b1;
      step(3);
      bus_b.sw_rst_req = 1'b0;
      n_cmp++; if ({bus_b.rst_out, bus_b.busy, bus_b.done} !== 3'b110) begin n_err++; $display("FAIL crn_e3 got %b want 110", {bus_b.rst_out, bus_b.busy, bus_b.done}); end
      step(1);
      n_cmp++; if ({bus_b.rst_out, bus_b.busy, bus_b.done} !== 3'b001) begin n_err++; $display("FAIL crn_e4 got %b want 001", {bus_b.rst_out, bus_b.busy, bus_b.done}); end
   endtask

   initial begin
      n_cmp            = 0;
      n_err            = 0;
      rst_n_a          = 1'b0;
      rst_n_b          = 1'b0;
      bus_a.sw_rst_req = 1'b0;
      bus_a.hold       = 1'b0;
      bus_b.sw_rst_req = 1'b0;
      bus_b.hold       = 1'b0;
      test_reset();
      test_powerup();
      test_async_mid();
      test_hold();
      test_sw_from_done();
      test_sw_hold_release();
      test_corner();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates the active-high asynchronous reset inputs that drive the team's flip-flop library cells. It sits directly upstream of every asynchronous-reset register bank. It takes one external active-low asynchronous reset and turns it into NUM_OUT reset lines that assert immediately, release synchronously, and release one after another with a programmable stretch and gap. It also re-runs the release sequence on a synchronous software reset request.

## Interface
- SYNC_STAGES, 2, synchronizer depth on reset deassertion; legal values ≥2.
- NUM_OUT, 4, number of sequenced reset outputs; legal values ≥1.
- STRETCH, 16, cycles between synchronized deassertion and release of rst_out[0]; legal values ≥1.
- GAP, 8, cycles between release of rst_out[k] and rst_out[k+1]; legal values ≥1.
- clk  input  1  single clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw_rst_req  input  1  synchronous software reset request, sampled every rising edge.
- hold  input  1  synchronous; freezes the sequence counter while high.
- rst_out  output  NUM_OUT  active-high resets for downstream flops; bit 0 releases first.
- busy  output  1  high while any rst_out bit is still high.
- done  output  1  high once the full sequence has completed.

## Operation
- The reset is asynchronous and active-low on rst_n. While rst_n=0:
  - rst_out = all ones, busy=1, done=0.
  - The synchronizer chain is cleared, the state is ASSERT and the counter is 0.
  - This takes effect immediately, with no clock edge required.
- State machine states:
  - ASSERT: waits for the last synchronizer stage to read 1.
  - STRETCH: counts STRETCH cycles.
  - RELEASE: clears one rst_out bit per GAP cycles, lowest index first.
  - DONE: rst_out=0, busy=0, done=1.
- Counter width is clog2(max(STRETCH,GAP)+1). The counter resets to 0 on every state entry and on every bit release.
- hold=1 in STRETCH or RELEASE freezes the counter, so no release happens that cycle. hold has no effect in ASSERT or DONE.
- sw_rst_req=1 sampled in STRETCH, RELEASE or DONE does all of the following on the same edge:
  - sets rst_out to all ones, busy=1, done=0;
  - enters STRETCH with the counter at 0.
- sw_rst_req is ignored in ASSERT.
- If sw_rst_req and hold are both high, sw_rst_req wins.
- rst_out, busy and done are driven directly from flops, so the outputs are glitch-free.
- Once a rst_out bit has released, it never re-asserts except through rst_n or sw_rst_req.

## Timing
- Reset assertion: rst_out goes high asynchronously on the falling edge of rst_n.
- Reset deassertion edges are counted from edge 1, the first rising edge of clk with rst_n=1. Assuming hold=0 throughout:
  - rst_out[0] falls after edge SYNC_STAGES+STRETCH.
  - rst_out[k] falls after edge SYNC_STAGES+STRETCH+k·GAP.
  - busy falls and done rises on the same edge as the last bit release.
- Software reset sampled at edge T:
  - All outputs re-assert after edge T.
  - rst_out[k] falls after edge T+STRETCH+k·GAP.
- Hold: each edge at which hold=1 is sampled in STRETCH or RELEASE delays every pending release by exactly one cycle.
- A short rst_n low pulse (less than one clock period) still asserts all outputs fully and restarts the sequence from ASSERT.
- rst_n falling mid-sequence always overrides the current state.
- NUM_OUT=1: done rises on the same edge that rst_out[0] falls.

## Test plan
- Power-up, defaults: rst_n rises before edge 1 with hold=0. Required response:
  - rst_out=1111 until edge 18;
  - 1110 after edge 18, 1100 after edge 26, 1000 after edge 34;
  - 0000 with done=1 and busy=0 after edge 42.
- Asynchronous assert mid-sequence: drop rst_n between clock edges while rst_out=1100. rst_out=1111 and done=0 before the next edge; after re-release the full sequence repeats from edge 1.
- Hold: hold=1 for 5 edges during STRETCH. Releases move to edges 23, 31, 39 and 47.
- Software reset from DONE: sw_rst_req pulsed at edge T. Required response:
  - rst_out=1111 and done=0 after edge T;
  - rst_out[0] releases after T+16 and rst_out[3] after T+40.
- Software reset during RELEASE, with hold=1 on the same edge: sw_rst_req wins, all bits re-assert, and STRETCH restarts from 0.
- Parameter corner case, SYNC_STAGES=3, NUM_OUT=1, STRETCH=1, GAP=1: rst_out falls and done rises after edge 4; sw_rst_req in ASSERT is ignored.
